// File: rtl/rv64im_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv64im_core : single-cycle RV64IM integer core, combinational ROM / RAM ports
// Revision    : 1.0
// ----------------------------------------------------------------------------
module rv64im_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [31:0]     INSTRUCTION,
  input  logic [XLEN-1:0] RAM_READ_DATA,
  output logic [9:0]      INSTRUCTION_ADDR,
  output logic [9:0]      RAM_ADDR,
  output logic [XLEN-1:0] RAM_WRITE_DATA,
  output logic            RAM_WRITE_ENABLE
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_v, rs2_v, op_b, pc4, wb_d, alu_r, m_r, ld_v;
  logic [31:0] r32;
  logic [5:0]  shamt;
  logic legal, is_reg, is_w, is_m, alt, wb_en, st, take;

  assign opc   = INSTRUCTION[6:0];
  assign rd    = INSTRUCTION[11:7];
  assign f3    = INSTRUCTION[14:12];
  assign rs1   = INSTRUCTION[19:15];
  assign rs2   = INSTRUCTION[24:20];
  assign f7    = INSTRUCTION[31:25];
  assign imm_i = {{52{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
  assign imm_s = {{52{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
  assign imm_b = {{51{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                  INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
  assign imm_u = {{32{INSTRUCTION[31]}}, INSTRUCTION[31:12], 12'd0};
  assign imm_j = {{43{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                  INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

  assign rs1_v  = rf_q[rs1];
  assign rs2_v  = rf_q[rs2];
  assign pc4    = pc_q + 64'd4;
  assign is_reg = (opc == OP_REG) || (opc == OP_REG32);
  assign is_w   = (opc == OP_IMM32) || (opc == OP_REG32);
  assign is_m   = is_reg && (f7 == 7'h01);
  assign op_b   = is_reg ? rs2_v : imm_i;
  assign shamt  = is_reg ? rs2_v[5:0] : INSTRUCTION[25:20];
  // bit 30 selects SUB / SRA; on ADDI it is only an immediate bit
  assign alt    = INSTRUCTION[30] && (is_reg || f3 == 3'd5);

  always_comb begin
    legal = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:  legal = (f3 == 3'd0);
      OP_BR:    legal = (f3[2:1] != 2'b01);
      OP_LD:    legal = (f3 != 3'd7);
      OP_ST:    legal = !f3[2];
      OP_IMM:   legal = (f3 == 3'd1) ? (INSTRUCTION[31:26] == 6'd0) :
                        (f3 == 3'd5) ? (INSTRUCTION[31:26] == 6'd0 || INSTRUCTION[31:26] == 6'b010000) :
                        1'b1;
      OP_IMM32: legal = (f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                        (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20));
      OP_REG:   legal = (f7 == 7'h00) || (f7 == 7'h01) ||
                        (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OP_REG32: legal = (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                        (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                        (f7 == 7'h01 && (f3 == 3'd0 || f3[2]));
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    case (f3)
      3'd0:    r32 = alt ? rs1_v[31:0] - op_b[31:0] : rs1_v[31:0] + op_b[31:0];
      3'd1:    r32 = rs1_v[31:0] << shamt[4:0];
      3'd5:    r32 = alt ? $unsigned($signed(rs1_v[31:0]) >>> shamt[4:0])
                         : rs1_v[31:0] >> shamt[4:0];
      default: r32 = 32'd0;
    endcase
    case (f3)
      3'd0:    alu_r = alt ? rs1_v - op_b : rs1_v + op_b;
      3'd1:    alu_r = rs1_v << shamt;
      3'd2:    alu_r = {63'd0, $signed(rs1_v) < $signed(op_b)};
      3'd3:    alu_r = {63'd0, rs1_v < op_b};
      3'd4:    alu_r = rs1_v ^ op_b;
      3'd5:    alu_r = alt ? $unsigned($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'd6:    alu_r = rs1_v | op_b;
      default: alu_r = rs1_v & op_b;
    endcase
    if (is_w) alu_r = {{32{r32[31]}}, r32};
  end

  logic [XLEN-1:0] ma, mb, quo, rem;
  logic [127:0]    prod;
  logic            a_sg, b_sg;

  always_comb begin
    // W forms pre-extend their operands so the 64-bit unit yields the 32-bit answer
    ma = rs1_v;
    mb = rs2_v;
    if (is_w) begin
      ma = f3[0] ? {32'd0, rs1_v[31:0]} : {{32{rs1_v[31]}}, rs1_v[31:0]};
      mb = f3[0] ? {32'd0, rs2_v[31:0]} : {{32{rs2_v[31]}}, rs2_v[31:0]};
    end
    a_sg = (f3[1:0] != 2'b11);
    b_sg = !f3[1];
    prod = 128'($signed({a_sg & ma[63], ma})) * 128'($signed({b_sg & mb[63], mb}));
    if (mb == '0) begin
      quo = '1;
      rem = ma;
    end else if (!f3[0] && ma == {1'b1, 63'd0} && mb == '1) begin
      quo = ma;
      rem = '0;
    end else if (!f3[0]) begin
      quo = $signed(ma) / $signed(mb);
      rem = $signed(ma) % $signed(mb);
    end else begin
      quo = ma / mb;
      rem = ma % mb;
    end
    case (f3)
      3'd0:             m_r = prod[63:0];
      3'd1, 3'd2, 3'd3: m_r = prod[127:64];
      3'd4, 3'd5:       m_r = quo;
      default:          m_r = rem;
    endcase
    if (is_w) m_r = {{32{m_r[31]}}, m_r[31:0]};
  end

  always_comb begin
    case (f3)
      3'd0:    ld_v = {{56{RAM_READ_DATA[7]}},  RAM_READ_DATA[7:0]};
      3'd1:    ld_v = {{48{RAM_READ_DATA[15]}}, RAM_READ_DATA[15:0]};
      3'd2:    ld_v = {{32{RAM_READ_DATA[31]}}, RAM_READ_DATA[31:0]};
      3'd4:    ld_v = {56'd0, RAM_READ_DATA[7:0]};
      3'd5:    ld_v = {48'd0, RAM_READ_DATA[15:0]};
      3'd6:    ld_v = {32'd0, RAM_READ_DATA[31:0]};
      default: ld_v = RAM_READ_DATA;
    endcase
    case (f3)
      3'd0:    take = (rs1_v == rs2_v);
      3'd1:    take = (rs1_v != rs2_v);
      3'd4:    take = $signed(rs1_v) <  $signed(rs2_v);
      3'd5:    take = $signed(rs1_v) >= $signed(rs2_v);
      3'd6:    take = rs1_v <  rs2_v;
      3'd7:    take = rs1_v >= rs2_v;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    wb_d  = alu_r;
    wb_en = legal && (rd != 5'd0);
    pc_d  = pc4;
    st    = 1'b0;
    case (opc)
      OP_LUI:   wb_d = imm_u;
      OP_AUIPC: wb_d = pc_q + imm_u;
      OP_JAL: begin
        wb_d = pc4;
        pc_d = pc_q + imm_j;
      end
      OP_JALR: begin
        wb_d = pc4;
        if (legal) pc_d = (rs1_v + imm_i) & ~64'd1;
      end
      OP_BR: begin
        wb_en = 1'b0;
        if (legal && take) pc_d = pc_q + imm_b;
      end
      OP_LD:    wb_d = ld_v;
      OP_ST: begin
        wb_en = 1'b0;
        st    = legal;
      end
      OP_REG, OP_REG32: wb_d = is_m ? m_r : alu_r;
      default:  wb_d = alu_r;
    endcase
  end

  assign INSTRUCTION_ADDR = pc_q[9:0];
  assign RAM_ADDR         = rs1_v[9:0] + ((opc == OP_ST) ? imm_s[9:0] : imm_i[9:0]);
  assign RAM_WRITE_DATA   = rs2_v;
  assign RAM_WRITE_ENABLE = st && RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (wb_en) rf_q[rd] <= wb_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv64im_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rv64im_core : scoreboard bench, per-cycle PC / store expectations
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_rv64im_core;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        RST_N = 1'b1;
  logic [31:0] INSTRUCTION;
  logic [63:0] RAM_READ_DATA;
  logic [9:0]  INSTRUCTION_ADDR, RAM_ADDR;
  logic [63:0] RAM_WRITE_DATA;
  logic        RAM_WRITE_ENABLE;

  logic [31:0] rom [256];
  logic [63:0] ram [128];

  rv64im_core dut (
    .CLK              (clk),
    .RST_N            (RST_N),
    .INSTRUCTION      (INSTRUCTION),
    .RAM_READ_DATA    (RAM_READ_DATA),
    .INSTRUCTION_ADDR (INSTRUCTION_ADDR),
    .RAM_ADDR         (RAM_ADDR),
    .RAM_WRITE_DATA   (RAM_WRITE_DATA),
    .RAM_WRITE_ENABLE (RAM_WRITE_ENABLE)
  );

  always #5 if (clk_en) clk = ~clk;

  assign INSTRUCTION   = rom[INSTRUCTION_ADDR[9:2]];
  assign RAM_READ_DATA = ram[RAM_ADDR[9:3]];
  always @(posedge clk) if (RAM_WRITE_ENABLE) ram[RAM_ADDR[9:3]] <= RAM_WRITE_DATA;

  typedef struct {
    logic [9:0]  pc;
    logic        we;
    logic [9:0]  addr;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;

  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] OPIW = 7'b0011011;
  localparam logic [6:0] OPRW = 7'b0111011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, int f3, int rd, int rs1, int rs2, logic [6:0] op);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(int off, int rs2, int rs1);
    logic [11:0] o;
    o = 12'(off);
    return {o[11:5], 5'(rs2), 5'(rs1), 3'd3, o[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int off, int rs1, int rs2, int f3);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(int off, int rd);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic put(input int addr, input logic [31:0] ins);
    rom[addr / 4] = ins;
  endtask
  task automatic expect_cyc(input int pc, input logic we, input int addr, input logic [63:0] data);
    exp_t e;
    e.pc = 10'(pc); e.we = we; e.addr = 10'(addr); e.data = data;
    sb.push_back(e);
  endtask
  task automatic op(input logic [31:0] ins);
    put(cur, ins);
    expect_cyc(cur, 1'b0, 0, 64'd0);
    cur += 4;
  endtask
  task automatic sd(input int rs2, input int off, input logic [63:0] data);
    put(cur, enc_s(off, rs2, 0));
    expect_cyc(cur, 1'b1, off, data);
    cur += 4;
  endtask
  task automatic load_nops();
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    sb.delete();
    cur = 0;
  endtask

  task automatic begin_prog();
    RST_N = 1'b0;
    #1;
    load_nops();
  endtask

  // pops one expectation per retired instruction; called with clk low
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      chk("pc", 64'(INSTRUCTION_ADDR), 64'(e.pc));
      chk("we", 64'(RAM_WRITE_ENABLE), 64'(e.we));
      if (e.we) begin
        chk("st_addr", 64'(RAM_ADDR), 64'(e.addr));
        chk("st_data", RAM_WRITE_DATA, e.data);
      end
      @(negedge clk);
    end
  endtask

  task automatic release_run();
    @(negedge clk);
    RST_N = 1'b1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // arithmetic basics, then an asynchronous reset with the clock stopped
    #2;
    begin_prog();
    chk("rst_pc", 64'(INSTRUCTION_ADDR), 64'd0);
    chk("rst_we", 64'(RAM_WRITE_ENABLE), 64'd0);
    op(enc_i(5, 0, 0, 1, OPI));
    op(enc_i(-3, 0, 0, 2, OPI));
    op(enc_r(7'h00, 0, 3, 1, 2, OPR));
    sd(3, 0, 64'd2);
    put(16, enc_s(8, 2, 0));
    release_run();
    #1;
    chk("pre_rst_we", 64'(RAM_WRITE_ENABLE), 64'd1);
    chk("pre_rst_pc", 64'(INSTRUCTION_ADDR), 64'd16);
    clk_en = 1'b0;
    #10;
    RST_N = 1'b0;
    #1;
    chk("async_rst_pc", 64'(INSTRUCTION_ADDR), 64'd0);
    chk("async_rst_we", 64'(RAM_WRITE_ENABLE), 64'd0);
    load_nops();
    sd(3, 0, 64'd0);
    sd(1, 8, 64'd0);
    sd(2, 16, 64'd0);
    #1;
    chk("rst_we_forced", 64'(RAM_WRITE_ENABLE), 64'd0);
    #8;
    RST_N  = 1'b1;
    clk_en = 1'b1;
    drain();

    // store / load round trip with narrow loads
    begin_prog();
    op(enc_i(42, 0, 0, 1, OPI));
    sd(1, 16, 64'd42);
    op(enc_i(16, 0, 3, 4, 7'b0000011));
    sd(4, 24, 64'd42);
    op(enc_i(-1, 0, 0, 5, OPI));
    sd(5, 32, 64'hFFFF_FFFF_FFFF_FFFF);
    op(enc_i(32, 0, 6, 6, 7'b0000011));
    sd(6, 40, 64'h0000_0000_FFFF_FFFF);
    op(enc_i(32, 0, 0, 7, 7'b0000011));
    sd(7, 48, 64'hFFFF_FFFF_FFFF_FFFF);
    release_run();

    // control flow
    begin_prog();
    put(0,  enc_b(8, 0, 0, 0));
    expect_cyc(0, 1'b0, 0, 0);
    put(8,  enc_j(12, 1));
    expect_cyc(8, 1'b0, 0, 0);
    put(20, enc_b(8, 0, 0, 1));
    expect_cyc(20, 1'b0, 0, 0);
    put(24, enc_s(32, 1, 0));
    expect_cyc(24, 1'b1, 32, 64'd12);
    put(28, enc_i(-1, 0, 0, 2, OPI));
    expect_cyc(28, 1'b0, 0, 0);
    put(32, enc_b(8, 0, 2, 6));
    expect_cyc(32, 1'b0, 0, 0);
    put(40, enc_b(8, 0, 2, 4));
    expect_cyc(40, 1'b0, 0, 0);
    put(44, enc_i(37, 1, 0, 3, 7'b1100111));
    expect_cyc(44, 1'b0, 0, 0);
    put(48, enc_s(0, 3, 0));
    expect_cyc(48, 1'b1, 0, 64'd48);
    release_run();

    // M extension, including divide-by-zero and overflow corners
    begin_prog();
    op(enc_i(-7, 0, 0, 1, OPI));
    op(enc_i(2, 0, 0, 2, OPI));
    op(enc_r(7'h01, 0, 3, 1, 2, OPR));  sd(3, 0,  64'hFFFF_FFFF_FFFF_FFF2);
    op(enc_r(7'h01, 4, 3, 1, 2, OPR));  sd(3, 8,  64'hFFFF_FFFF_FFFF_FFFD);
    op(enc_r(7'h01, 6, 3, 1, 2, OPR));  sd(3, 16, 64'hFFFF_FFFF_FFFF_FFFF);
    op(enc_r(7'h01, 4, 3, 1, 0, OPR));  sd(3, 24, 64'hFFFF_FFFF_FFFF_FFFF);
    op(enc_r(7'h01, 7, 3, 1, 0, OPR));  sd(3, 32, 64'hFFFF_FFFF_FFFF_FFF9);
    op(enc_r(7'h01, 3, 3, 1, 2, OPR));  sd(3, 40, 64'd1);
    op(enc_r(7'h01, 1, 3, 1, 2, OPR));  sd(3, 48, 64'hFFFF_FFFF_FFFF_FFFF);
    op({20'h80000, 5'd4, 7'b0110111});
    op(enc_i(-1, 0, 0, 5, OPI));
    op(enc_i(32, 4, 1, 6, OPI));
    op(enc_r(7'h01, 4, 7, 6, 5, OPR));  sd(7, 56, 64'h8000_0000_0000_0000);
    op(enc_r(7'h01, 6, 7, 6, 5, OPR));  sd(7, 64, 64'd0);
    op(enc_r(7'h01, 4, 7, 4, 5, OPRW)); sd(7, 72, 64'hFFFF_FFFF_8000_0000);
    op(enc_r(7'h01, 6, 7, 4, 5, OPRW)); sd(7, 80, 64'd0);
    op(enc_r(7'h01, 5, 7, 1, 0, OPRW)); sd(7, 88, 64'hFFFF_FFFF_FFFF_FFFF);
    op(enc_r(7'h01, 2, 3, 2, 1, OPR));  sd(3, 96, 64'd1);
    release_run();

    // 32-bit forms, shifts and NOP-like encodings
    begin_prog();
    op(enc_i(-1, 0, 0, 1, OPIW));
    op(enc_i(1, 1, 5, 2, OPIW));
    op({20'h80000, 5'd3, 7'b0110111});
    sd(2, 0, 64'h0000_0000_7FFF_FFFF);
    sd(3, 8, 64'hFFFF_FFFF_8000_0000);
    op(enc_i(12'h404, 3, 5, 4, OPIW));
    sd(4, 16, 64'hFFFF_FFFF_F800_0000);
    op(enc_r(7'h20, 0, 5, 0, 1, OPRW));
    sd(5, 24, 64'd1);
    op(enc_i(12'h43F, 3, 5, 6, OPI));
    sd(6, 32, 64'hFFFF_FFFF_FFFF_FFFF);
    op(32'h0000_0073);
    op(32'h0000_028F);
    sd(5, 40, 64'd1);
    release_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv64im_core.md
Name: rv64im_core

Overview:
- Single-cycle RV64IM integer core; one instruction retires per rising CLK.
- Fetches 32-bit instructions from a combinational instruction ROM.
- Loads and stores go to a 64-bit-wide data RAM with combinational read and write on the clock edge.
- Sits between the instruction ROM and data RAM at the top of the system.

Parameters:
- RESET_PC, 0, value loaded into the program counter on reset.
- XLEN, 64, register and datapath width. Fixed at 64; not intended to be overridden.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- INSTRUCTION  input  32  instruction word at INSTRUCTION_ADDR, valid combinationally.
- RAM_READ_DATA  input  64  doubleword at RAM_ADDR, valid combinationally.
- INSTRUCTION_ADDR  output  10  PC[9:0], byte address.
- RAM_ADDR  output  10  effective address (rs1 + imm)[9:0], byte address.
- RAM_WRITE_DATA  output  64  rs2 value for stores.
- RAM_WRITE_ENABLE  output  1  high for the whole cycle of a store instruction.

Behaviour:
Reset:
- While RST_N is low: PC = RESET_PC, all 32 registers = 0, RAM_WRITE_ENABLE forced to 0.
- First fetch after reset release is from address 0.
- Reset asserted mid-run takes effect immediately, without waiting for a clock edge.

Per-cycle operation:
- Decode, execute, memory access and writeback are all combinational from PC and INSTRUCTION.
- At the rising CLK edge: PC is updated, rd is written, and the RAM commits any store at the same edge.

Register file:
- 32 x 64-bit registers.
- x0 always reads 0; writes to x0 are ignored.
- Two read ports are combinational. An instruction reading rd in the same cycle sees the old value.

Instructions, RV64I:
- LUI, AUIPC, JAL, JALR. JALR clears target bit 0; rd = PC+4.
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI; SLLI/SRLI/SRAI with a 6-bit shamt.
- ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount = rs2[5:0].
- ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW:
  - operate on the low 32 bits, shift amount uses 5 bits;
  - the 32-bit result is sign-extended to 64.

Instructions, M extension:
- MUL returns the low 64 bits of the product.
- MULH, MULHSU, MULHU return the high 64 bits of the 128-bit product.
- DIV, DIVU, REM, REMU.
- MULW, DIVW, DIVUW, REMW, REMUW; 32-bit results are sign-extended.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (most-negative / -1): quotient = dividend, remainder = 0. The W forms apply the same rules at 32 bits.

Loads and stores:
- Loads use RAM_READ_DATA.
  - LD takes all 64 bits.
  - LW/LH/LB take the low 32/16/8 bits, sign-extended.
  - LWU/LHU/LBU take the same bits, zero-extended.
- Stores: SD, SW, SH, SB all drive the full rs2 onto RAM_WRITE_DATA with RAM_WRITE_ENABLE = 1. The RAM has no byte enables, so the narrow stores write 64 bits.

Next PC:
- PC+4, or branch/JAL target PC+imm, or JALR target.
- Misaligned targets are not trapped; the PC wraps modulo 2^64.

Other encodings:
- FENCE, ECALL, EBREAK and unrecognised encodings execute as NOP: PC+4, no register or RAM write.

Outputs:
- RAM_ADDR and RAM_WRITE_DATA are don't-care when not storing or loading, but must be deterministic.

Test Plan:
- Reset then ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> x3 = 2; INSTRUCTION_ADDR sequence 0, 4, 8, 12.
- ADDI x1,x0,42; SD x1,16(x0); LD x4,16(x0) -> RAM_WRITE_ENABLE = 1 only in the SD cycle with RAM_ADDR = 16; x4 = 42.
- BEQ x0,x0,+8 -> PC jumps 0->8. BNE x0,x0,+8 -> PC 0->4. JAL x1,+12 at PC 8 -> x1 = 12, PC = 20.
- x1 = -7, x2 = 2:
  - MUL -> -14; DIV -> -3; REM -> -1;
  - DIV by x0 -> 0xFFFF_FFFF_FFFF_FFFF;
  - REMU by x0 -> x1.
- ADDIW x1,x0,-1 then SRLIW x2,x1,1 -> x2 = 0x0000_0000_7FFF_FFFF; LUI x3,0x80000 -> 0xFFFF_FFFF_8000_0000.
- Assert RST_N low mid-run with CLK stopped -> PC = 0, x-registers = 0, RAM_WRITE_ENABLE = 0 immediately; after release, execution restarts at 0.
